// File: rtl/pe_scan_pipe.sv
// pe_scan_pipe: pipelined, handshaked SCAN f1/f2 processing-element array.
// Processes one tree-node job of nbeats beats. Each beat carries P LLR lanes, and each lane is
// computed with saturating min-sum arithmetic. The pipeline has two stages with full backpressure.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, nbeats, mode job start pulse (sampled in IDLE only), beat count and f1/f2 enables
//   in_valid/in_ready   input beat handshake; a, b, c, d are P lanes of WIDTH bits each
//   out_valid/out_ready output beat handshake; out = {o2, o1}; out_last tags the final beat
//   busy                high while a job is running or draining
//   done                one-cycle pulse when a job completes
module pe_scan_pipe #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned P     = 64,
  parameter int unsigned MAXB  = 8,
  parameter int unsigned CW    = $clog2(MAXB + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CW-1:0]          nbeats,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [P*WIDTH-1:0]     a,
  input  logic [P*WIDTH-1:0]     b,
  input  logic [P*WIDTH-1:0]     c,
  input  logic [P*WIDTH-1:0]     d,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*P*WIDTH-1:0]   out,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam logic [WIDTH:0]   SatHi   = (WIDTH + 1)'((1 << (WIDTH - 1)) - 1);
  localparam logic [WIDTH:0]   SatLo   = -SatHi;
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  // Symmetric clamp of a (WIDTH+1)-bit two's-complement sum back to WIDTH bits.
  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] x);
    if ($signed(x) > $signed(SatHi)) return SatHi[WIDTH-1:0];
    else if ($signed(x) < $signed(SatLo)) return SatLo[WIDTH-1:0];
    else return x[WIDTH-1:0];
  endfunction

  // The asymmetric most-negative code is folded onto -(2^(WIDTH-1)-1).
  function automatic logic [WIDTH-1:0] clampin(input logic [WIDTH-1:0] x);
    return (x == MostNeg) ? SatLo[WIDTH-1:0] : x;
  endfunction

  function automatic logic [WIDTH:0] sext(input logic [WIDTH-1:0] x);
    return {x[WIDTH-1], x};
  endfunction

  // The input is already clamped, so |x| always fits in WIDTH-1 bits.
  function automatic logic [WIDTH-2:0] mag(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] n;
    n = x[WIDTH-1] ? -x : x;
    return n[WIDTH-2:0];
  endfunction

  // Min-sum kernel. A zero magnitude gives +0 because -0 == 0 in two's complement.
  function automatic logic [WIDTH-1:0] fmin(input logic sx, input logic [WIDTH-2:0] mx,
                                            input logic sy, input logic [WIDTH-2:0] my);
    logic [WIDTH-1:0] m;
    m = {1'b0, (mx < my) ? mx : my};
    return (sx ^ sy) ? -m : m;
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e        state_q;
  logic [CW-1:0] count_q, nbeats_q;
  logic [1:0]    mode_q;
  logic          busy_q, done_q;

  // Stage 1: the clamped operands, split into sign and magnitude, plus the saturated b+c.
  logic                    s1_valid_q, s1_last_q;
  logic [P-1:0]            s1_asgn_q, s1_bcsgn_q, s1_dsgn_q;
  logic [P-1:0]            s1_asgn_d, s1_bcsgn_d, s1_dsgn_d;
  logic [P-1:0][WIDTH-2:0] s1_amag_q, s1_bcmag_q, s1_dmag_q;
  logic [P-1:0][WIDTH-2:0] s1_amag_d, s1_bcmag_d, s1_dmag_d;
  logic [P-1:0][WIDTH-1:0] s1_b_q, s1_b_d;

  // Stage 2: the finished o1/o2 lanes.
  logic [P-1:0][WIDTH-1:0] o1_d, o2_d;
  logic                    out_valid_q, out_last_q;
  logic [2*P*WIDTH-1:0]    out_q;

  logic s2_load, s1_load, accept, out_fire, beat_last;

  assign s2_load   = !out_valid_q || out_ready;
  assign s1_load   = s2_load || !s1_valid_q;
  assign in_ready  = (state_q == StRun) && s1_load;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign beat_last = (count_q == nbeats_q - CW'(1));

  for (genvar i = 0; i < P; i++) begin : g_lane
    logic [WIDTH-1:0] la, lb, lc, ld, lbc, f2;

    assign la  = clampin(a[i*WIDTH +: WIDTH]);
    assign lb  = clampin(b[i*WIDTH +: WIDTH]);
    assign lc  = clampin(c[i*WIDTH +: WIDTH]);
    assign ld  = clampin(d[i*WIDTH +: WIDTH]);
    assign lbc = sat(sext(lb) + sext(lc));

    assign s1_asgn_d[i]  = la[WIDTH-1];
    assign s1_amag_d[i]  = mag(la);
    assign s1_bcsgn_d[i] = lbc[WIDTH-1];
    assign s1_bcmag_d[i] = mag(lbc);
    assign s1_dsgn_d[i]  = ld[WIDTH-1];
    assign s1_dmag_d[i]  = mag(ld);
    assign s1_b_d[i]     = lb;

    assign o1_d[i] = mode_q[0] ? fmin(s1_asgn_q[i], s1_amag_q[i], s1_bcsgn_q[i], s1_bcmag_q[i])
                               : '0;
    assign f2      = fmin(s1_asgn_q[i], s1_amag_q[i], s1_dsgn_q[i], s1_dmag_q[i]);
    assign o2_d[i] = mode_q[1] ? sat(sext(f2) + sext(s1_b_q[i])) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_asgn_q   <= '0;
      s1_bcsgn_q  <= '0;
      s1_dsgn_q   <= '0;
      s1_amag_q   <= '0;
      s1_bcmag_q  <= '0;
      s1_dmag_q   <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_q       <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_last_q  <= beat_last;
          s1_asgn_q  <= s1_asgn_d;
          s1_bcsgn_q <= s1_bcsgn_d;
          s1_dsgn_q  <= s1_dsgn_d;
          s1_amag_q  <= s1_amag_d;
          s1_bcmag_q <= s1_bcmag_d;
          s1_dmag_q  <= s1_dmag_d;
          s1_b_q     <= s1_b_d;
        end
      end
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_valid_q && s1_last_q;
        if (s1_valid_q) out_q <= {o2_d, o1_d};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      nbeats_q <= '0;
      mode_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (nbeats != '0) begin
              state_q  <= StRun;
              count_q  <= '0;
              nbeats_q <= nbeats;
              mode_q   <= mode;
              busy_q   <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (accept) begin
            count_q <= count_q + CW'(1);
            if (beat_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (out_fire && out_last_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pe_scan_pipe.sv
// Self-checking bench for pe_scan_pipe (WIDTH=6, P=4). The driver pushes expected beats into a
// scoreboard queue as they are accepted. A negedge monitor pops the queue and compares each beat
// as it leaves the DUT. Expected values come from an integer model of the min-sum rules.
module tb_pe_scan_pipe;
  localparam int W    = 6;
  localparam int P    = 4;
  localparam int MAXB = 8;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int DW   = P * W;
  localparam int MAXV = (1 << (W - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] nbeats;
  logic [1:0]    mode;
  logic          in_valid, in_ready;
  logic [DW-1:0] a, b, c, d;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*DW-1:0] out;
  logic          out_last, busy, done;

  pe_scan_pipe #(.WIDTH(W), .P(P), .MAXB(MAXB)) dut (
    .clk(clk), .rst(rst), .start(start), .nbeats(nbeats), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*DW-1:0] o;
    bit              last;
    int              cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         total = 0, bad = 0, cyc = 0, outs = 0, rpat = 0;
  int         rdy_mode = 0;
  int         job_nb = 0, job_idx = 0;
  logic [1:0] job_mode = 2'd0;
  bit         tb_accepting = 0;
  bit         held_v = 0;
  logic [2*DW-1:0] held;

  // ---------------- reference model ----------------
  function automatic int m_sat(input int x);
    return (x < -MAXV) ? -MAXV : ((x > MAXV) ? MAXV : x);
  endfunction

  function automatic int m_f(input int x, input int y);
    int ax, ay, m;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    m  = (ax < ay) ? ax : ay;
    return ((x < 0) != (y < 0)) ? -m : m;
  endfunction

  function automatic int lane(input logic [DW-1:0] v, input int i);
    logic [W-1:0] s;
    s = v[i*W +: W];
    return m_sat(int'($signed(s)));
  endfunction

  function automatic logic [2*DW-1:0] model(input logic [1:0] md,
                                            input logic [DW-1:0] va, vb, vc, vd);
    logic [2*DW-1:0] r;
    int ai, bi, ci, di, o1, o2;
    r = '0;
    for (int i = 0; i < P; i++) begin
      ai = lane(va, i); bi = lane(vb, i); ci = lane(vc, i); di = lane(vd, i);
      o1 = md[0] ? m_f(ai, m_sat(bi + ci)) : 0;
      o2 = md[1] ? m_sat(m_f(ai, di) + bi) : 0;
      r[i*W +: W]      = W'(o1);
      r[DW + i*W +: W] = W'(o2);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rep(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < P; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // ---------------- out_ready generator and cycle counter ----------------
  always @(posedge clk) begin
    cyc++;
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: begin out_ready = (rpat % 3 == 0); rpat++; end
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      held_v = 0;
    end else begin
      if (in_valid && !tb_accepting) chk("stray_accept", in_ready, 0);
      if (out_valid) begin
        if (held_v) chk("hold_stable", out, held);
        if (out_ready) begin
          held_v = 0;
          outs++;
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: got beat %0h with empty scoreboard, want none", out);
          end else begin
            mon_e = sbq.pop_front();
            chk("out_data", out, mon_e.o);
            chk("out_last", out_last, mon_e.last);
            if (rdy_mode == 0) chk("latency", cyc - mon_e.cyc, 2);
          end
        end else begin
          held_v = 1;
          held   = out;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_beat(input logic [DW-1:0] va, vb, vc, vd, input bit use_exp,
                           input logic [2*DW-1:0] ex, input bit rv, input bit poke);
    bit   acc = 0;
    int   n = 0;
    exp_t e;
    a = va; b = vb; c = vc; d = vd;
    while (!acc) begin
      in_valid = rv ? ($urandom_range(0, 3) != 0) : 1'b1;
      start    = poke && (n == 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc    = 1;
        e.o    = use_exp ? ex : model(job_mode, va, vb, vc, vd);
        e.last = (job_idx == job_nb - 1);
        e.cyc  = cyc;
        sbq.push_back(e);
        job_idx++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (!acc && n > 200) begin
        total++; bad++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, want an accept", n);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int nb, input int outs0);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 400);
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, want a pulse", n);
    end else begin
      chk("busy_at_done", busy, 0);
      chk("job_beats", outs - outs0, nb);
      chk("sb_empty", sbq.size(), 0);
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
  endtask

  task automatic kick(input int nb, input logic [1:0] md);
    @(posedge clk); #1;
    start = 1'b1; nbeats = CW'(nb); mode = md; in_valid = 1'b1;
    job_mode = md; job_nb = nb; job_idx = 0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  // dir: 0 random lanes, 1 and 2 fixed lane values with hand-computed results.
  task automatic run_job(input int nb, input logic [1:0] md, input int dir, input bit rv,
                         input int rmode, input int poke_at);
    int outs0;
    rdy_mode = rmode;
    outs0 = outs;
    kick(nb, md);
    if (nb == 0) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      repeat (4) begin @(negedge clk); chk("zero_done_pulse", done, 0); end
      chk("zero_no_out", outs - outs0, 0);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      @(posedge clk); #1;
      tb_accepting = 1;
      for (int k = 0; k < nb; k++) begin
        if (dir == 1)
          send_beat(rep(10), rep(20), rep(15), rep(-7), 1, {rep(13), rep(10)}, rv, k == poke_at);
        else if (dir == 2)
          send_beat(rep(-32), rep(-31), rep(-5), rep(12), 1, {rep(-31), rep(31)}, rv,
                    k == poke_at);
        else
          send_beat(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 0, '0, rv,
                    k == poke_at);
      end
      tb_accepting = 0;
      in_valid = 1'b1;
      a = DW'($urandom);
      wait_done(nb, outs0);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; nbeats = '0; mode = 2'd0; in_valid = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed lane values with known results.
    run_job(1, 2'd3, 1, 0, 0, -1);
    run_job(1, 2'd3, 2, 0, 0, -1);
    run_job(2, 2'd3, 2, 0, 0, -1);
    // Mode selects.
    run_job(2, 2'd1, 0, 0, 0, -1);
    run_job(3, 2'd2, 0, 0, 0, -1);
    run_job(3, 2'd0, 0, 0, 0, -1);
    // Stall pattern 1,0,0,1,...
    rpat = 0;
    run_job(3, 2'd3, 0, 0, 2, -1);
    // Zero-beat job, and a start pulse issued mid-job.
    run_job(0, 2'd3, 0, 0, 0, -1);
    run_job(5, 2'd3, 0, 0, 0, 1);
    run_job(MAXB, 2'd3, 0, 1, 1, 3);

    // Reset with two beats in flight.
    rdy_mode = 0;
    kick(4, 2'd3);
    tb_accepting = 1;
    repeat (2) send_beat(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 0, '0,
                         0, 0);
    chk("inflight_pre_rst", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_out", out, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_in_ready", in_ready, 0);
    chk("rstmid_out_last", out_last, 0);
    sbq.delete();
    tb_accepting = 0;
    repeat (2) begin @(negedge clk); chk("rstmid_no_done", done, 0); end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", out_valid, 0);
    end
    run_job(2, 2'd3, 0, 0, 0, -1);

    // Random jobs.
    for (int j = 0; j < 20; j++)
      run_job($urandom_range(1, MAXB), 2'($urandom_range(0, 3)), 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 2), -1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
